xoodoo_state_shares_reg: RTL
============================

// Module: xoodoo_state_shares_reg
// PURPOSE
// - N-share masked Xoodoo state register with word-serial absorb/squeeze port. Successor to the fixed 2-share/32-bit state register.
// - Sits between the Xoodyak mode controller and the masked permutation core.
// - Adds: valid/ready word handshake, auto-incrementing lane index, XOR/overwrite modes, byte enables, busy tracking.
// PARAMETERS
// - NSHARES  2   number of Boolean shares (>=2)
// - LANES    12  lanes in state
// - LANE_W   32  bits per lane (multiple of 8)
// - IDX_W    4   lane index width, >= clog2(LANES)
// - DOM_LANE 11  lane receiving domain constant
// PORTS
// - clk             in   1                     clock
// - rst_n           in   1                     synchronous reset, active low
// - init            in   1                     clear state and index
// - perm_load       in   1                     capture perm_state_in (start|running)
// - perm_state_in   in   NSHARES*LANES*LANE_W  share s lane l at [(s*LANES+l)*LANE_W +: LANE_W]
// - perm_state_out  out  NSHARES*LANES*LANE_W  current state, same packing
// - idx_load        in   1                     load lane index from idx_in
// - idx_in          in   IDX_W                 explicit lane index
// - word_valid      in   1                     beat offered
// - word_ready      out  1                     beat accepted when valid&ready
// - word_data       in   NSHARES*LANE_W        share s at [s*LANE_W +: LANE_W]
// - word_be         in   LANE_W/8              byte enables
// - word_ovw        in   1                     1 = overwrite enabled bytes, 0 = XOR
// - word_last       in   1                     last beat of burst; index returns to 0
// - domain_valid    in   1                     XOR domain_i into last share of DOM_LANE
// - domain_i        in   LANE_W                domain constant
// - word_out        out  NSHARES*LANE_W        shares of lane at current index (combinational)
// - cur_idx         out  IDX_W                 current lane index
// - busy            out  1                     high while in PERM
// BEHAVIOUR
// - Reset (rst_n=0 at edge): all shares 0, cur_idx 0, FSM IDLE, busy 0, word_ready 0.
// - Priority per edge: reset > init > perm_load > idx_load > beat/domain.
// - FSM IDLE->PERM on perm_load; PERM->IDLE when perm_load drops; busy=(state==PERM).
// - init from any state: shares 0, cur_idx 0, FSM IDLE.
// - word_ready = rst_n & ~init & ~perm_load & ~busy & ~idx_load. Combinational; no dependency on word_valid.
// - Accepted beat: for each share s and enabled byte b:
//   - XOR mode: lane[idx][s][b] ^= data[s][b]
//   - Overwrite mode: lane[idx][s][b] = data[s][b]
//   - Disabled bytes unchanged. Result visible on word_out next cycle.
// - Index after beat: 0 if word_last or idx==LANES-1 (wrap), else idx+1.
// - idx_load: cur_idx <= idx_in. idx_in >= LANES loads 0.
// - domain_valid: honoured only when no init/perm_load. Same cycle as beat on DOM_LANE: beat result, then domain XOR, both in one update.
// - perm_load: all shares replaced by perm_state_in. cur_idx held. Concurrent word_valid is not accepted.
// - Reset or init mid-burst: beat is dropped and index cleared; no partial write.
// - Unmasked value = XOR of all shares; never formed internally.
// CONFIGURATION
// - Macro SHARE_REFRESH_EN.
//   - Defined: extra input rand_i [(NSHARES-1)*LANE_W]. On every accepted beat, share s<NSHARES-1 of the written lane additionally ^= rand_i[s]; last share ^= XOR of all rand_i words. Unmasked value unchanged.
//   - Undefined: port absent; no refresh.
// STRUCTURE
// - Package xoodoo_sca_pkg: LANES, LANE_W, DOM_LANE defaults, share/lane packing index functions, FSM state enum (IDLE, PERM).
// - One sub-module xoodoo_lane_update: per-lane next-value logic (XOR/overwrite, byte enables, domain, refresh); instantiated LANES times via generate.
// TESTING
// - Reset then word_valid=1: word_ready=0 during reset; after release, word_out=0, cur_idx=0, busy=0.
// - 12 XOR beats, data share0=0x11111111*k, share1=0 (k=1..12), last on 12th: every lane k share0=0x11111111*k; cur_idx=0.
//   - Repeat with be=4'b0001, ovw=1, data 0xAA: only byte0 becomes 0xAA.
// - perm_load 3 cycles with pattern P, word_valid held: word_ready=0, busy=1 for 3 cycles, state=P, no beat consumed.
// - Beat on lane 11 (share1 ^=0x5) plus domain_valid domain_i=0x03 same cycle: lane11 share1 = 0x06.
// - idx_load idx_in=13 then beat: write lands at lane 0; next cur_idx=1. init mid-burst clears state and index.
// - SHARE_REFRESH_EN, random rand_i, NSHARES=3: XOR of shares per lane equals non-refresh build result.

Source files
------------

// File: rtl/xoodoo_sca_pkg.sv
// xoodoo_sca_pkg: shared defaults, state/word packing helpers and FSM encoding for the masked Xoodoo state register
package xoodoo_sca_pkg;
  localparam int NSHARES_DEF = 2;
  localparam int LANES_DEF = 12;
  localparam int LANE_W_DEF = 32;
  localparam int DOM_LANE_DEF = 11;
  typedef enum logic {IDLE, PERM} state_t;
  function automatic int lane_off(int s, int l, int lanes, int w);
    return (s * lanes + l) * w;
  endfunction
  function automatic int share_off(int s, int w);
    return s * w;
  endfunction
endpackage

// File: rtl/xoodoo_state_shares_reg_if.sv
// xoodoo_state_shares_reg_if: word-serial absorb/squeeze beat channel
// Signals: word_valid/word_ready handshake, word_data (share s at [s*LANE_W +: LANE_W]),
// word_be byte enables, word_ovw (1 overwrite, 0 XOR), word_last (burst end, index returns to 0).
interface xoodoo_state_shares_reg_if #(
  parameter int NSHARES = 2,
  parameter int LANE_W = 32
);
  logic word_valid;
  logic word_ready;
  logic [NSHARES*LANE_W-1:0] word_data;
  logic [LANE_W/8-1:0] word_be;
  logic word_ovw;
  logic word_last;
  modport master(output word_valid, word_data, word_be, word_ovw, word_last, input word_ready);
  modport slave(input word_valid, word_data, word_be, word_ovw, word_last, output word_ready);
endinterface

// File: rtl/xoodoo_lane_update.sv
// xoodoo_lane_update: next value of one lane (all shares) for a beat, domain XOR and optional share refresh
// Ports: cur/nxt lane shares (share s at [s*LANE_W +: LANE_W]); beat = accepted beat targets this lane;
// data/be/ovw beat payload; dom_en/domain domain XOR into the last share; rand_i only with SHARE_REFRESH_EN.
module xoodoo_lane_update
  import xoodoo_sca_pkg::*;
#(
  parameter int NSHARES = NSHARES_DEF,
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [NSHARES*LANE_W-1:0]     cur,
  input  logic                          beat,
  input  logic [NSHARES*LANE_W-1:0]     data,
  input  logic [LANE_W/8-1:0]           be,
  input  logic                          ovw,
  input  logic                          dom_en,
  input  logic [LANE_W-1:0]             domain,
`ifdef SHARE_REFRESH_EN
  input  logic [(NSHARES-1)*LANE_W-1:0] rand_i,
`endif
  output logic [NSHARES*LANE_W-1:0]     nxt
);
  localparam int LAST = (NSHARES - 1) * LANE_W;
  always_comb begin
    nxt = cur;
    for (int s = 0; s < NSHARES; s++)
      for (int b = 0; b < LANE_W / 8; b++)
        if (beat && be[b])
          nxt[share_off(s, LANE_W) + 8*b +: 8] = ovw ? data[share_off(s, LANE_W) + 8*b +: 8]
                                                     : cur[share_off(s, LANE_W) + 8*b +: 8] ^ data[share_off(s, LANE_W) + 8*b +: 8];
`ifdef SHARE_REFRESH_EN
    // each mask word enters one share and the last share, so the unmasked value is preserved
    if (beat)
      for (int s = 0; s < NSHARES - 1; s++) begin
        nxt[share_off(s, LANE_W) +: LANE_W] ^= rand_i[share_off(s, LANE_W) +: LANE_W];
        nxt[LAST +: LANE_W] ^= rand_i[share_off(s, LANE_W) +: LANE_W];
      end
`endif
    if (dom_en) nxt[LAST +: LANE_W] ^= domain;
  end
endmodule

// File: rtl/xoodoo_state_shares_reg.sv
// xoodoo_state_shares_reg: N-share masked Xoodoo state register with word-serial absorb/squeeze port
// Ports: clk; rst_n sync active-low reset; init clears state/index; perm_load/perm_state_in capture
// permutation output (busy while held); perm_state_out full state (share s lane l at [(s*LANES+l)*LANE_W]);
// idx_load/idx_in explicit lane index; w beat channel (slave); domain_valid/domain_i domain XOR into the
// last share of DOM_LANE; word_out shares of the current lane; cur_idx; busy.
// Optional feature macro SHARE_REFRESH_EN adds rand_i and refreshes the masking on every accepted beat.
module xoodoo_state_shares_reg
  import xoodoo_sca_pkg::*;
#(
  parameter int NSHARES = NSHARES_DEF,
  parameter int LANES = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int IDX_W = 4,
  parameter int DOM_LANE = DOM_LANE_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              init,
  input  logic                              perm_load,
  input  logic [NSHARES*LANES*LANE_W-1:0]   perm_state_in,
  output logic [NSHARES*LANES*LANE_W-1:0]   perm_state_out,
  input  logic                              idx_load,
  input  logic [IDX_W-1:0]                  idx_in,
  xoodoo_state_shares_reg_if.slave          w,
  input  logic                              domain_valid,
  input  logic [LANE_W-1:0]                 domain_i,
`ifdef SHARE_REFRESH_EN
  input  logic [(NSHARES-1)*LANE_W-1:0]     rand_i,
`endif
  output logic [NSHARES*LANE_W-1:0]         word_out,
  output logic [IDX_W-1:0]                  cur_idx,
  output logic                              busy
);
  state_t state_q, state_d;
  logic [NSHARES*LANES*LANE_W-1:0] st_q, st_d;
  logic [IDX_W-1:0] idx_d;
  logic accept, dom_ok;
  assign w.word_ready = rst_n & ~init & ~perm_load & ~busy & ~idx_load;
  assign accept = w.word_valid & w.word_ready;
  assign dom_ok = domain_valid & ~init & ~perm_load;
  assign busy = state_q == PERM;
  assign perm_state_out = st_q;
  always_comb state_d = (init || !perm_load) ? IDLE : PERM;
  always_comb
    idx_d = idx_load ? (({1'b0, idx_in} < (IDX_W+1)'(LANES)) ? idx_in : '0)
          : accept ? ((w.word_last || cur_idx == IDX_W'(LANES - 1)) ? '0 : cur_idx + 1'b1)
          : cur_idx;
  always_comb begin
    word_out = '0;
    for (int s = 0; s < NSHARES; s++)
      word_out[share_off(s, LANE_W) +: LANE_W] = st_q[lane_off(s, int'(cur_idx), LANES, LANE_W) +: LANE_W];
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [NSHARES*LANE_W-1:0] cur, nxt;
    for (genvar s = 0; s < NSHARES; s++) begin : g_sh
      assign cur[s*LANE_W +: LANE_W] = st_q[lane_off(s, l, LANES, LANE_W) +: LANE_W];
      assign st_d[lane_off(s, l, LANES, LANE_W) +: LANE_W] = nxt[s*LANE_W +: LANE_W];
    end
    xoodoo_lane_update #(.NSHARES(NSHARES), .LANE_W(LANE_W)) u_lane (
      .cur    (cur),
      .beat   (accept && cur_idx == IDX_W'(l)),
      .data   (w.word_data),
      .be     (w.word_be),
      .ovw    (w.word_ovw),
      .dom_en (dom_ok && l == DOM_LANE),
      .domain (domain_i),
`ifdef SHARE_REFRESH_EN
      .rand_i (rand_i),
`endif
      .nxt    (nxt)
    );
  end
  always_ff @(posedge clk)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk)
    if (!rst_n) begin
      st_q <= '0;
      cur_idx <= '0;
    end else begin
      st_q <= init ? '0 : perm_load ? perm_state_in : st_d;
      cur_idx <= init ? '0 : perm_load ? cur_idx : idx_d;
    end
endmodule
